// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if
// Handshake and status bundle for sync_fifo_fwft.
//   master : producer/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives read data, flags, count, error pulses)
// Signals:
//   wr_en, wr_data   write request and word
//   rd_en            pop request / acknowledge of the displayed word
//   rd_data/rd_valid read word and its qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow/underflow   one-cycle pulses for rejected write/read
interface sync_fifo_fwft_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     rd_en;
    logic [WIDTH-1:0]         rd_data;
    logic                     rd_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock FIFO with selectable read style:
//   FWFT=0 : registered read, rd_data loads on an accepted pop and
//            rd_valid pulses for one cycle.
//   FWFT=1 : first-word-fall-through, head word shown combinationally,
//            rd_valid = !empty, rd_en acknowledges the shown word.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (pointers, count, outputs)
//   bus  sync_fifo_fwft_if.slave (write/read handshake and status)
// Status flags are decoded from the registered count, so they always
// describe occupancy after the most recent edge.
module sync_fifo_fwft #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_fwft_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_fwft: WIDTH must be >= 1");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_fwft: DEPTH must be a power of two >= 4");
        end
        if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
            $error("sync_fifo_fwft: AF_LEVEL out of range");
        end
        if (AE_LEVEL >= DEPTH || AE_LEVEL < 0) begin : g_bad_ae
            $error("sync_fifo_fwft: AE_LEVEL out of range");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
            $error("sync_fifo_fwft: FWFT must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          underflow_reg;

    logic full_flag;
    logic empty_flag;
    logic wr_accept;
    logic rd_accept;

    assign full_flag  = (count_reg == FULL_CNT);
    assign empty_flag = (count_reg == '0);

    // A full FIFO can still pop, an empty one can still push; the other
    // half of a simultaneous request is the one that gets rejected.
    assign wr_accept = bus.wr_en && !full_flag;
    assign rd_accept = bus.rd_en && !empty_flag;

    // Storage has no reset so it can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so wrap is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            overflow_reg  <= bus.wr_en && full_flag;
            underflow_reg <= bus.rd_en && empty_flag;
        end
    end

    assign bus.full         = full_flag;
    assign bus.empty        = empty_flag;
    assign bus.almost_full  = (count_reg >= AF_CNT);
    assign bus.almost_empty = (count_reg <= AE_CNT);
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] rd_data_reg;
            logic             rd_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        rd_data_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign bus.rd_data  = rd_data_reg;
            assign bus.rd_valid = rd_valid_reg;
        end else begin : g_fwft
            // Gate the head word while empty so rd_data reads as zero in
            // reset and never exposes a stale or unwritten location.
            assign bus.rd_data  = empty_flag ? '0 : mem[rd_ptr_reg];
            assign bus.rd_valid = !empty_flag;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;
    localparam int W = 8;
    localparam int D = 16;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] wr_data;

    int checks   = 0;
    int failures = 0;

    sync_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    sync_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    assign if0.wr_en   = wr_en;
    assign if0.rd_en   = rd_en;
    assign if0.wr_data = wr_data;
    assign if1.wr_en   = wr_en;
    assign if1.rd_en   = rd_en;
    assign if1.wr_data = wr_data;

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue holding the stored words, plus the
    // expected registered-read output and error pulses.
    logic [W-1:0] q[$];
    logic [W-1:0] m_rd;
    bit           m_valid;
    bit           m_ov;
    bit           m_un;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rd    = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        check("count_std",  if0.count, n);
        check("count_fwft", if1.count, n);
        check("full",       if0.full, n == D);
        check("empty",      if0.empty, n == 0);
        check("afull",      if0.almost_full, n >= D - 2);
        check("aempty",     if0.almost_empty, n <= 2);
        check("overflow",   if0.overflow, m_ov);
        check("underflow",  if0.underflow, m_un);
        check("ovf_fwft",   if1.overflow, m_ov);
        check("unf_fwft",   if1.underflow, m_un);
        check("valid_std",  if0.rd_valid, m_valid);
        check("data_std",   if0.rd_data, m_rd);
        check("valid_fwft", if1.rd_valid, n != 0);
        if (n != 0) begin
            check("head_fwft", if1.rd_data, q[0]);
        end
    endtask

    // One clock: drive requests, advance the model, sample 1 time unit
    // after the edge.
    task automatic cycle(input bit w, input bit r, input logic [W-1:0] d);
        bit wok;
        bit rok;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        wok = w && (q.size() < D);
        rok = r && (q.size() > 0);
        m_ov    = w && !wok;
        m_un    = r && !rok;
        m_valid = rok;
        if (rok) m_rd = q.pop_front();
        if (wok) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] wdata;
        int           exp_count;
        bit           exp_empty;
        bit           exp_valid;
        logic [W-1:0] exp_rd;
        bit           exp_un;
        bit           exp_fvalid;
        logic [W-1:0] exp_frd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        model_clear();

        // Three writes, three registered reads, then an underflow.
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00};

        #1;
        check("rst_count",  if0.count, 0);
        check("rst_empty",  if0.empty, 1);
        check("rst_aempty", if0.almost_empty, 1);
        check("rst_full",   if0.full, 0);
        check("rst_afull",  if0.almost_full, 0);
        check("rst_valid",  if0.rd_valid, 0);
        check("rst_data",   if0.rd_data, 0);
        check("rst_fvalid", if1.rd_valid, 0);
        check("rst_fdata",  if1.rd_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven basic sequence; first request lands on the first
        // edge after reset release.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            check($sformatf("tbl%0d_count", i), if0.count, vecs[i].exp_count);
            check($sformatf("tbl%0d_empty", i), if0.empty, vecs[i].exp_empty);
            check($sformatf("tbl%0d_valid", i), if0.rd_valid, vecs[i].exp_valid);
            check($sformatf("tbl%0d_rd", i), if0.rd_data, vecs[i].exp_rd);
            check($sformatf("tbl%0d_unf", i), if0.underflow, vecs[i].exp_un);
            check($sformatf("tbl%0d_fvalid", i), if1.rd_valid, vecs[i].exp_fvalid);
            if (vecs[i].exp_fvalid) begin
                check($sformatf("tbl%0d_frd", i), if1.rd_data, vecs[i].exp_frd);
            end
        end

        // Fill to full, overflow, simultaneous ops at full, drain.
        do_reset();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, 1'b0, W'(i));
            check($sformatf("fill%0d_afull", i), if0.almost_full, (i + 1) >= 14);
            check($sformatf("fill%0d_full", i), if0.full, (i + 1) == 16);
        end
        cycle(1'b1, 1'b0, 8'h10);
        check("ovf17_pulse", if0.overflow, 1);
        check("ovf17_count", if0.count, 16);
        cycle(1'b0, 1'b0, 8'h00);
        check("ovf_pulse_end", if0.overflow, 0);
        cycle(1'b1, 1'b1, 8'hEE);
        check("fullboth_data",  if0.rd_data, 8'h00);
        check("fullboth_valid", if0.rd_valid, 1);
        check("fullboth_ovf",   if0.overflow, 1);
        check("fullboth_count", if0.count, 15);
        for (int i = 1; i < D; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d", i), if0.rd_data, i);
        end
        check("drain_last", if0.rd_data, 8'h0F);
        check("drain_empty", if0.empty, 1);
        cycle(1'b1, 1'b1, 8'h77);
        check("emptyboth_unf",   if0.underflow, 1);
        check("emptyboth_count", if0.count, 1);
        check("emptyboth_fhead", if1.rd_data, 8'h77);
        cycle(1'b0, 1'b1, 8'h00);

        // Interleaved write/read pairs across pointer wrap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, W'(8'h40 + i));
            check($sformatf("wrap%0d_cnt_w", i), if0.count, 1);
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap%0d_data", i), if0.rd_data, 8'h40 + i);
            check($sformatf("wrap%0d_cnt_r", i), if0.count, 0);
        end

        // FWFT fall-through into an empty FIFO.
        do_reset();
        cycle(1'b1, 1'b0, 8'hA5);
        check("fwft_head",  if1.rd_data, 8'hA5);
        check("fwft_valid", if1.rd_valid, 1);
        cycle(1'b0, 1'b1, 8'h00);
        check("fwft_pop_valid", if1.rd_valid, 0);
        check("fwft_pop_empty", if1.empty, 1);

        // Reset asserted between edges discards contents at once.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(8'hC0 + i));
        cycle(1'b0, 1'b1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("midrst_count",  if0.count, 0);
        check("midrst_empty",  if0.empty, 1);
        check("midrst_valid",  if0.rd_valid, 0);
        check("midrst_fvalid", if1.rd_valid, 0);
        check("midrst_fcount", if1.count, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h5A);
        check("postrst_fhead", if1.rd_data, 8'h5A);
        cycle(1'b0, 1'b1, 8'h00);
        check("postrst_data", if0.rd_data, 8'h5A);

        // Randomized traffic against the queue model, alternating
        // fill-heavy and drain-heavy phases to hit both ends.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            int pw;
            bit w;
            bit r;
            if (k == 500) do_reset();
            pw = (((k / 100) % 2) == 0) ? 75 : 25;
            w = ($urandom_range(99) < pw);
            r = ($urandom_range(99) < (100 - pw));
            cycle(w, r, W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, storage words; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full threshold in words.
- AE_LEVEL, 2, almost_empty threshold in words.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write word.
- rd_en  in  1  read (pop) request.
- rd_data  out  WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid popped/head word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  words stored.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Function
REQ-003 Write SHALL be accepted iff wr_en && !full; accepted word stored at wr_ptr, wr_ptr advances by 1 modulo DEPTH.
REQ-004 Read SHALL be accepted iff rd_en && !empty; rd_ptr advances by 1 modulo DEPTH.
REQ-005 Pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally, no modulo arithmetic.
REQ-006 count SHALL update at the same edge as the accepted operation: +1 write only, -1 read only, unchanged for both or neither.
REQ-007 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered count, so they reflect the count after the most recent edge (no extra cycle lag).
REQ-008 Simultaneous wr_en && rd_en when full: read accepted, write rejected (overflow pulses), count becomes DEPTH-1.
REQ-009 Simultaneous wr_en && rd_en when empty: write accepted, read rejected (underflow pulses), count becomes 1.
REQ-010 overflow SHALL be high for exactly the cycle after the edge on which a write was rejected; underflow likewise for a rejected read.
REQ-011 FWFT=0: on an accepted read, rd_data SHALL load mem[rd_ptr] at that edge and rd_valid SHALL be high for the following cycle only; rd_data holds its value otherwise.
REQ-012 FWFT=1: rd_data SHALL equal mem[rd_ptr] combinationally and rd_valid SHALL equal !empty; rd_en acts as pop/acknowledge of the displayed word.
REQ-013 FWFT=1: a word written into an empty FIFO SHALL appear on rd_data with rd_valid high in the cycle after its write edge.
REQ-014 Memory contents SHALL NOT be reset; only pointers, count, and outputs are reset.
REQ-015 Parameter violations (DEPTH not power of two, AF_LEVEL > DEPTH, AE_LEVEL >= DEPTH) SHALL be rejected at elaboration.

Reset
REQ-016 rst high SHALL immediately, without clk, force wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; thus empty=1, almost_empty=1, full=0, almost_full=0.
REQ-017 Reset asserted mid-operation SHALL discard all stored words; the first operation after release behaves as on an empty FIFO.
REQ-018 Requests during the first edge after rst deassertion SHALL be honoured normally.

Verification
REQ-019 FWFT=0, write 0x11,0x22,0x33 then read 3 -> rd_data 0x11,0x22,0x33 each one cycle after rd_en with rd_valid pulse; count 3->0; empty=1 at end.
REQ-020 Write 16 words (0x00..0x0F) -> almost_full at count 14, full at 16; 17th write -> overflow pulse, count stays 16, word 0x0F remains last read out.
REQ-021 Full FIFO, wr_en && rd_en same cycle -> 0x00 popped, write rejected, overflow=1, count=15; empty FIFO with both -> underflow=1, count=1.
REQ-022 Wrap: 20 interleaved write/read pairs with incrementing data through pointer wrap -> output sequence matches input exactly, count never exceeds 1.
REQ-023 FWFT=1, write 0xA5 to empty -> next cycle rd_data=0xA5, rd_valid=1 without rd_en; assert rd_en -> following cycle rd_valid=0, empty=1.
REQ-024 Load 5 words, assert rst between clock edges -> count=0, empty=1, rd_valid=0 immediately; after release write 0x5A, read -> 0x5A.
